ps_channel_scheduler: RTL

Round-robin scheduler that shares one `P_S` parallel-to-serial converter between up to 8 byte-wide sample sources (ADC channels). It grants one requester at a time and presents that requester's byte on the converter's `data` input. It fires the converter's active-low start/clear strobe `nGet_AD_data`, tracks the converter's `link_S_out` frame window, and acknowledges the requester when the 8-bit frame has been shifted out. It sits between the per-channel sample registers and the serial link.

---
 rtl/ps_channel_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ps_channel_scheduler.sv
// Round-robin scheduler sharing one P_S parallel-to-serial converter among N_CH byte sources.
// Grants one channel, strobes nGet_AD_data, tracks the link_S_out frame and acks on completion.
module ps_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  input  logic [8*N_CH-1:0] ch_data,
  input  logic              link_S_out,
  output logic [7:0]        data,
  output logic              nGet_AD_data,
  output logic [N_CH-1:0]   ack,
  output logic [2:0]        cur_ch,
  output logic              busy,
  output logic              err
);

  localparam logic [6:0] TMO_HI = 7'(TIMEOUT);
  localparam logic [6:0] TMO_LO = 7'(2 * TIMEOUT + 8);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t      r_state;
  logic [2:0]  r_lastCh;
  logic [3:0]  r_gapCnt;
  logic [6:0]  r_tcnt;

  logic [7:0]  w_reqX;
  logic [63:0] w_dataX;
  logic [7:0]  w_ackOneHot;
  logic        w_found;
  logic [2:0]  w_pick;
  logic [3:0]  w_idx;

  assign w_reqX      = 8'(req);
  assign w_dataX     = 64'(ch_data);
  assign w_ackOneHot = 8'd1 << cur_ch;
  assign busy        = (r_state != IDLE);

  // Scan downward from the farthest candidate so the one nearest last_ch+1 wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = 4'(r_lastCh) + 4'(k);
      if (w_idx >= 4'(N_CH)) w_idx = w_idx - 4'(N_CH);
      if (w_reqX[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      nGet_AD_data <= 1'b0;
      data         <= '0;
      ack          <= '0;
      err          <= 1'b0;
      cur_ch       <= '0;
      r_lastCh     <= 3'(N_CH - 1);
      r_gapCnt     <= '0;
      r_tcnt       <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (r_state)
        IDLE: begin
          nGet_AD_data <= 1'b1;
          if (r_gapCnt != 4'd0) begin
            r_gapCnt <= r_gapCnt - 4'd1;
          end else if (w_found) begin
            cur_ch       <= w_pick;
            data         <= w_dataX[{w_pick, 3'b000} +: 8];
            nGet_AD_data <= 1'b0;
            r_state      <= START;
          end
        end
        START: begin
          nGet_AD_data <= 1'b1;
          r_tcnt       <= '0;
          r_state      <= WAIT_HI;
        end
        WAIT_HI: begin
          if (link_S_out) begin
            r_tcnt  <= '0;
            r_state <= WAIT_LO;
          end else if (r_tcnt == TMO_HI) begin
            err      <= 1'b1;
            r_lastCh <= cur_ch;
            r_gapCnt <= 4'(GAP);
            r_state  <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 7'd1;
          end
        end
        WAIT_LO: begin
          // Aborts also advance last_ch so a stuck channel cannot starve the rest.
          if (!link_S_out) begin
            ack      <= w_ackOneHot[N_CH-1:0];
            r_lastCh <= cur_ch;
            r_gapCnt <= 4'(GAP);
            r_state  <= IDLE;
          end else if (r_tcnt == TMO_LO) begin
            err      <= 1'b1;
            r_lastCh <= cur_ch;
            r_gapCnt <= 4'(GAP);
            r_state  <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 7'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
